// File: rtl/hazard_stall_unit.sv
// Hazard/stall controller beside the ID stage: load-use and branch-compare stalls, taken-branch IF/ID flush.
// Optional HAZARD_STATS_EN adds saturating stall/flush statistics counters.
module hazard_stall_unit #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       Rs_ID,
    input  logic [4:0]       Rt_ID,
    input  logic             uses_rt_ID,
    input  logic             branch,
    input  logic             branch_taken,
    input  logic             memread_IDEX,
    input  logic             regwrite_IDEX,
    input  logic [4:0]       Rd_IDEX,
    input  logic             memread_EXMEM,
    input  logic [4:0]       Rd_EXMEM,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic {S_RUN = 1'b0, S_HOLD = 1'b1} state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_cnt;
    logic       w_cnt_nxt;
    logic       w_m_ex;
    logic       w_m_mem;
    logic [1:0] w_need;
    logic       w_in_hold;
    logic       w_stall;
    logic       w_flush;

    assign w_m_ex  = (Rd_IDEX != 5'd0) &&
                     ((Rd_IDEX == Rs_ID) || (uses_rt_ID && (Rd_IDEX == Rt_ID)));
    assign w_m_mem = (Rd_EXMEM != 5'd0) &&
                     ((Rd_EXMEM == Rs_ID) || (uses_rt_ID && (Rd_EXMEM == Rt_ID)));

    // First matching rule wins; a load in EX feeding a branch needs two cycles.
    always_comb begin
        w_need = 2'd0;
        if (branch && memread_IDEX && w_m_ex)
            w_need = 2'd2;
        else if (branch && memread_EXMEM && w_m_mem)
            w_need = 2'd1;
        else if (branch && regwrite_IDEX && w_m_ex)
            w_need = 2'd1;
        else if (memread_IDEX && w_m_ex)
            w_need = 2'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_RUN: begin
                if (w_need == 2'd2) begin
                    w_state_nxt = S_HOLD;
                    w_cnt_nxt   = 1'b1;
                end
            end
            S_HOLD: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (w_cnt_nxt == 1'b0)
                    w_state_nxt = S_RUN;
            end
            default: begin
                w_state_nxt = S_RUN;
                w_cnt_nxt   = 1'b0;
            end
        endcase
    end

    // While reset is held the RUN rules apply, so a pending HOLD never forces a stall.
    always_comb begin
        w_in_hold   = (r_state == S_HOLD) && rst_n;
        w_stall     = w_in_hold || (w_need != 2'd0);
        w_flush     = branch && branch_taken && !w_stall;
        pc_write    = !w_stall;
        ifid_write  = !w_stall;
        idex_bubble = w_stall;
        ifid_flush  = w_flush;
    end

`ifdef HAZARD_STATS_EN
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_flush_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
        end else begin
            if (w_stall && (r_stall_cycles != {CNT_W{1'b1}}))
                r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (w_flush && (r_flush_count != {CNT_W{1'b1}}))
                r_flush_count <= r_flush_count + CNT_W'(1);
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule
